// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI primary: FSM states, SPI mode codes
// and the slave-select index width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int spi_ssw(input int nss);
    return (nss > 1) ? $clog2(nss) : 1;
  endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCLK generator: down-counting half-period divider with a terminal-count strobe,
// plus leading/trailing edge strobes that coincide with the registered SCLK toggle.
module spi_clkgen #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  input  logic xfer,
  input  logic lvl,
  output logic half_tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  assign half_tick  = run && (cnt == '0);
  assign lead_edge  = half_tick && xfer && !phase;
  assign trail_edge = half_tick && xfer && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
      sclk  <= 1'b0;
    end else begin
      if (load || half_tick)
        cnt <= RELOAD;
      else if (run)
        cnt <= cnt - CW'(1);
      else
        cnt <= '0;

      // Outside XFER the line simply follows the requested idle level.
      if (!xfer) begin
        phase <= 1'b0;
        sclk  <= lvl;
      end else if (half_tick) begin
        phase <= ~phase;
        sclk  <= ~sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI primary with CPOL/CPHA modes, divided SCLK and decoded slave selects.
// Optional SPI_MASTER_IRQ_EN adds a sticky completion interrupt cleared by a host read.
//
// state | meaning
// IDLE  | done=1, ss_n released, sclk follows cpol input, waits for cs&wr
// LEAD  | slave selected, sclk at idle level for one half-period
// XFER  | 2*DWIDTH SCLK half-periods, shifting mosi and sampling miso
// TRAIL | slave still selected for one half-period, then result to dout
module spi_master
  import spi_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CLKDIV = 2,
  parameter int NSS    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic [spi_ssw(NSS)-1:0]  ssel,
  output logic [DWIDTH-1:0]        dout,
  output logic                     done,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic [NSS-1:0]           ss_n
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int SSW = spi_ssw(NSS);
  localparam int BW  = $clog2(DWIDTH);

  spi_state_t        state, state_nxt;
  logic [DWIDTH-1:0] tx_sh, rx_sh;
  logic [1:0]        mode_q;
  logic [BW-1:0]     bit_cnt;
  logic              start, busy, last_edge, sample_lead, sclk_lvl;
  logic              half_tick, lead_edge, trail_edge, finish;

  function automatic logic [NSS-1:0] sel_decode(input logic [SSW-1:0] idx);
    logic [NSS-1:0] m;
    m = '1;
    for (int i = 0; i < NSS; i++)
      if (idx == SSW'(i)) m[i] = 1'b0;
    return m;
  endfunction

  assign start     = (state == IDLE) && cs && wr;
  assign busy      = (state != IDLE);
  assign done      = !busy;
  assign last_edge = trail_edge && (bit_cnt == '0);
  assign finish    = (state == TRAIL) && half_tick;
  assign sclk_lvl  = busy ? mode_q[1] : cpol;

  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start),
    .run        (busy),
    .xfer       (state == XFER),
    .lvl        (sclk_lvl),
    .half_tick  (half_tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LEAD;
      LEAD:    if (half_tick) state_nxt = XFER;
      XFER:    if (last_edge) state_nxt = TRAIL;
      TRAIL:   if (half_tick) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sample_lead = 1'b1;
    case (mode_q)
      MODE0, MODE2: sample_lead = 1'b1;
      MODE1, MODE3: sample_lead = 1'b0;
      default:      sample_lead = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      mode_q  <= MODE0;
      bit_cnt <= '0;
      mosi    <= 1'b0;
      dout    <= '0;
      ss_n    <= '1;
    end else begin
      if (start) begin
        tx_sh   <= din;
        rx_sh   <= '0;
        mode_q  <= {cpol, cpha};
        bit_cnt <= BW'(DWIDTH - 1);
        mosi    <= din[DWIDTH-1];
        ss_n    <= sel_decode(ssel);
      end
      if (lead_edge) begin
        if (sample_lead) begin
          rx_sh <= {rx_sh[DWIDTH-2:0], miso};
        end else begin
          mosi  <= tx_sh[DWIDTH-1];
          tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
        end
      end
      if (trail_edge) begin
        // With cpha=0 the MSB is already on mosi, so the trailing edge presents the next bit.
        if (sample_lead) begin
          mosi  <= tx_sh[DWIDTH-2];
          tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
        end else begin
          rx_sh <= {rx_sh[DWIDTH-2:0], miso};
        end
        if (bit_cnt != '0) bit_cnt <= bit_cnt - BW'(1);
      end
      if (finish) begin
        dout <= rx_sh;
        ss_n <= '1;
      end
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                irq <= 1'b0;
    else if (finish)           irq <= 1'b1;
    else if (cs && rd && !wr)  irq <= 1'b0;
  end
`else
  logic unused_rd;
  assign unused_rd = rd;
`endif

endmodule
